// File: rtl/ilkn_pkg.sv
// Shared Interlaken constants: block types, 64b/67b headers, control word patterns,
// CRC-32C polynomial/seed and the metaframe slot encoding.
package ilkn_pkg;

   localparam logic [5:0]  BT_SCR_STATE   = 6'b001010;
   localparam logic [5:0]  BT_DIAG        = 6'b011001;

   localparam logic [1:0]  HDR_DATA       = 2'b01;
   localparam logic [1:0]  HDR_CTRL       = 2'b10;

   localparam logic [63:0] ILKN_SYNC_WORD = 64'h78f678f678f678f6;
   localparam logic [63:0] ILKN_SKIP_WORD = 64'h1e1e1e1e1e1e1e1e;
   localparam logic [63:0] ILKN_IDLE_WORD = 64'h8000000000000000;

   localparam logic [31:0] CRC32C_POLY    = 32'h1EDC6F41;
   localparam logic [31:0] CRC32C_SEED    = 32'hFFFFFFFF;

   typedef enum logic [2:0] {
      SLOT_SYNC,
      SLOT_SCR_STATE,
      SLOT_SKIP,
      SLOT_PAYLOAD,
      SLOT_DIAG
   } slot_t;

   // One MSB-first CRC-32C bit step (non-reflected shift register).
   function automatic logic [31:0] crc32c_bit(input logic [31:0] crc, input logic din);
      logic fb;
      fb = crc[31] ^ din;
      return {crc[30:0], 1'b0} ^ (fb ? CRC32C_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/ilkn_tx_framer_if.sv
// Framer bus bundle: payload handshake from the burst layer, lane status in, word/header
// out to the scrambler. slave = framer side, master = upstream/downstream environment.
interface ilkn_tx_framer_if;

   logic [63:0] DATA_IN;
   logic [1:0]  HEADER_IN;
   logic        DATA_VALID_IN;
   logic        DATA_READY_OUT;
   logic [1:0]  STATUS_IN;
   logic [63:0] TX_DATA_OUT;
   logic [1:0]  TX_HEADER_OUT;

   modport slave (
      input  DATA_IN, HEADER_IN, DATA_VALID_IN, STATUS_IN,
      output DATA_READY_OUT, TX_DATA_OUT, TX_HEADER_OUT
   );

   modport master (
      output DATA_IN, HEADER_IN, DATA_VALID_IN, STATUS_IN,
      input  DATA_READY_OUT, TX_DATA_OUT, TX_HEADER_OUT
   );

endinterface

// File: rtl/ilkn_crc32c_64.sv
// Combinational CRC-32C update over one 64-bit word, bit 63 first; zero latency, no handshake.
module ilkn_crc32c_64
   import ilkn_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [63:0] data,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in;
      for (int i = 63; i >= 0; i--) begin
         crc_out = crc32c_bit(crc_out, data[i]);
      end
   end

endmodule

// File: rtl/ilkn_tx_framer.sv
// Interlaken TX metaframe framer; 1-cycle registered output, one word every cycle; ready only in
// payload slots, independent of valid. Diagnostic CRC-32C present when ILKN_TX_DIAG_CRC32_EN is defined.
module ilkn_tx_framer
   import ilkn_pkg::*;
#(
   parameter int          METAFRAME_LENGTH = 2048,
   parameter logic [63:0] SYNC_WORD        = ILKN_SYNC_WORD,
   parameter logic [63:0] SKIP_WORD        = ILKN_SKIP_WORD,
   parameter logic [63:0] IDLE_WORD        = ILKN_IDLE_WORD
)
(
   input  logic             USER_CLK,
   input  logic             SYSTEM_RESET,
   ilkn_tx_framer_if.slave  bus
);

   localparam logic [15:0] WCNT_LAST = 16'(METAFRAME_LENGTH - 1);

   logic [15:0] wcnt_q, wcnt_d;
   logic [63:0] tx_data_q, tx_data_d;
   logic [1:0]  tx_hdr_q, tx_hdr_d;

   slot_t       slot;
   logic [63:0] word_base;
   logic [31:0] crc_field;

   always_comb begin
      slot = SLOT_PAYLOAD;
      if (wcnt_q == 16'd0) begin
         slot = SLOT_SYNC;
      end else if (wcnt_q == 16'd1) begin
         slot = SLOT_SCR_STATE;
      end else if (wcnt_q == 16'd2) begin
         slot = SLOT_SKIP;
      end else if (wcnt_q == WCNT_LAST) begin
         slot = SLOT_DIAG;
      end
   end

   assign bus.DATA_READY_OUT = !SYSTEM_RESET && (slot == SLOT_PAYLOAD);

   // word_base is the emitted word with the Diagnostic CRC field still zero; the CRC runs over it.
   always_comb begin
      word_base = IDLE_WORD;
      tx_hdr_d  = HDR_CTRL;
      case (slot)
         SLOT_SYNC:      word_base = SYNC_WORD;
         SLOT_SCR_STATE: word_base = {BT_SCR_STATE, 58'b0};
         SLOT_SKIP:      word_base = SKIP_WORD;
         SLOT_DIAG:      word_base = {BT_DIAG, 24'b0, bus.STATUS_IN, 32'b0};
         SLOT_PAYLOAD: begin
            if (bus.DATA_VALID_IN) begin
               word_base = bus.DATA_IN;
               tx_hdr_d  = bus.HEADER_IN;
            end
         end
         default: word_base = IDLE_WORD;
      endcase
      tx_data_d = word_base | {32'b0, crc_field};
      wcnt_d    = (wcnt_q == WCNT_LAST) ? 16'd0 : wcnt_q + 16'd1;
   end

`ifdef ILKN_TX_DIAG_CRC32_EN
   logic [31:0] crc_q, crc_d;
   logic [31:0] crc_in, crc_out;

   // Sync always restarts from the seed, so a stale crc_q can never leak across metaframes.
   assign crc_in = (slot == SLOT_SYNC) ? CRC32C_SEED : crc_q;

   ilkn_crc32c_64 u_crc (
      .crc_in  (crc_in),
      .data    (word_base),
      .crc_out (crc_out)
   );

   always_comb begin
      crc_field = 32'h0;
      crc_d     = crc_out;
      if (slot == SLOT_DIAG) begin
         crc_field = ~crc_out;
         crc_d     = CRC32C_SEED;
      end
   end

   always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         crc_q <= CRC32C_SEED;
      end else begin
         crc_q <= crc_d;
      end
   end
`else
   assign crc_field = 32'h0;
`endif

   always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
      if (SYSTEM_RESET) begin
         wcnt_q    <= 16'd0;
         tx_data_q <= 64'h0;
         tx_hdr_q  <= HDR_DATA;
      end else begin
         wcnt_q    <= wcnt_d;
         tx_data_q <= tx_data_d;
         tx_hdr_q  <= tx_hdr_d;
      end
   end

   assign bus.TX_DATA_OUT   = tx_data_q;
   assign bus.TX_HEADER_OUT = tx_hdr_q;

endmodule

// File: tb/tb_ilkn_tx_framer.sv
// Directed bench for ilkn_tx_framer: an L=8 and an L=5 instance run side by side against
// a small reference model; honours ILKN_TX_DIAG_CRC32_EN for the Diagnostic CRC field.
module tb_ilkn_tx_framer;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

`ifdef ILKN_TX_DIAG_CRC32_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   ilkn_tx_framer_if if8 ();
   ilkn_tx_framer_if if5 ();

   ilkn_tx_framer #(.METAFRAME_LENGTH(8)) dut8 (
      .USER_CLK     (clk),
      .SYSTEM_RESET (rst),
      .bus          (if8)
   );

   ilkn_tx_framer #(.METAFRAME_LENGTH(5)) dut5 (
      .USER_CLK     (clk),
      .SYSTEM_RESET (rst),
      .bus          (if5)
   );

   int checks   = 0;
   int failures = 0;

   int          cnt8 = 0, cnt5 = 0;
   int          seq8 = 0, seq5 = 0;
   logic [31:0] crc8 = 32'hFFFFFFFF, crc5 = 32'hFFFFFFFF;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [63:0] w);
      logic [31:0] r;
      r = c;
      for (int i = 63; i >= 0; i--) begin
         if (r[31] ^ w[i]) r = (r << 1) ^ 32'h1EDC6F41;
         else              r = r << 1;
      end
      return r;
   endfunction

   // Expected word/header for slot c of an L-word metaframe, plus the running CRC.
   task automatic model(input int L, input int c, input bit v, input logic [63:0] d,
                        input logic [1:0] h, input logic [1:0] st, input logic [31:0] crc,
                        output logic [63:0] od, output logic [1:0] oh,
                        output logic [31:0] ncrc, output bit rdy, output bit take);
      logic [31:0] cin;
      rdy  = (c >= 3) && (c <= L - 2);
      take = rdy && v;
      oh   = 2'b10;
      cin  = (c == 0) ? 32'hFFFFFFFF : crc;
      if (c == 0)          od = 64'h78f678f678f678f6;
      else if (c == 1)     od = 64'h2800000000000000;
      else if (c == 2)     od = 64'h1e1e1e1e1e1e1e1e;
      else if (c == L - 1) od = {6'b011001, 24'b0, st, 32'b0};
      else if (take) begin
         od = d;
         oh = h;
      end else             od = 64'h8000000000000000;
      ncrc = ref_crc(cin, od);
      if (c == L - 1 && CRC_ON) od[31:0] = ~ncrc;
   endtask

   task automatic tick(input bit v, input logic [1:0] st);
      logic [63:0] d8, d5, e8, e5;
      logic [1:0]  h8, h5, eh8, eh5;
      logic [31:0] n8, n5;
      bit          r8, r5, t8, t5;
      int          c8, c5;
      c8 = cnt8;
      c5 = cnt5;
      d8 = 64'hD8D8_0000_0000_0000 + 64'(seq8);
      d5 = 64'h5D5D_0000_0000_0000 + 64'(seq5);
      h8 = seq8[0] ? 2'b10 : 2'b01;
      h5 = seq5[0] ? 2'b10 : 2'b01;
      if8.DATA_IN = d8; if8.HEADER_IN = h8; if8.DATA_VALID_IN = v; if8.STATUS_IN = st;
      if5.DATA_IN = d5; if5.HEADER_IN = h5; if5.DATA_VALID_IN = v; if5.STATUS_IN = st;
      model(8, c8, v, d8, h8, st, crc8, e8, eh8, n8, r8, t8);
      model(5, c5, v, d5, h5, st, crc5, e5, eh5, n5, r5, t5);
      check_eq($sformatf("rdy8_w%0d", c8), 64'(if8.DATA_READY_OUT), 64'(r8));
      check_eq($sformatf("rdy5_w%0d", c5), 64'(if5.DATA_READY_OUT), 64'(r5));
      @(posedge clk);
      #1;
      check_eq($sformatf("dat8_w%0d", c8), if8.TX_DATA_OUT, e8);
      check_eq($sformatf("hdr8_w%0d", c8), 64'(if8.TX_HEADER_OUT), 64'(eh8));
      check_eq($sformatf("dat5_w%0d", c5), if5.TX_DATA_OUT, e5);
      check_eq($sformatf("hdr5_w%0d", c5), 64'(if5.TX_HEADER_OUT), 64'(eh5));
      if (c8 == 7) begin
         check_eq("diag8_status", 64'(if8.TX_DATA_OUT[33:32]), 64'(st));
         if (!CRC_ON) check_eq("diag8_crc_zero", 64'(if8.TX_DATA_OUT[31:0]), 64'h0);
      end
      cnt8 = (c8 == 7) ? 0 : c8 + 1;
      cnt5 = (c5 == 4) ? 0 : c5 + 1;
      crc8 = n8;
      crc5 = n5;
      if (t8) seq8++;
      if (t5) seq5++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_dat8"}, if8.TX_DATA_OUT, 64'h0);
      check_eq({tag, "_hdr8"}, 64'(if8.TX_HEADER_OUT), 64'h1);
      check_eq({tag, "_rdy8"}, 64'(if8.DATA_READY_OUT), 64'h0);
      check_eq({tag, "_dat5"}, if5.TX_DATA_OUT, 64'h0);
      check_eq({tag, "_rdy5"}, 64'(if5.DATA_READY_OUT), 64'h0);
   endtask

   initial begin
      if8.DATA_IN = '0; if8.HEADER_IN = 2'b01; if8.DATA_VALID_IN = 1'b0; if8.STATUS_IN = 2'b00;
      if5.DATA_IN = '0; if5.HEADER_IN = 2'b01; if5.DATA_VALID_IN = 1'b0; if5.STATUS_IN = 2'b00;
      #1 rst = 1'b1;
      #1 check_reset_outputs("por");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Continuous valid, incrementing payload: two full L=8 periods.
      for (int i = 0; i < 16; i++) tick(1'b1, 2'b01);
      // Nothing offered: payload slots carry Idle.
      for (int i = 0; i < 8; i++) tick(1'b0, 2'b10);
      // Valid toggling, both status bits set.
      for (int i = 0; i < 16; i++) tick(i[0] == 1'b0, 2'b11);

      // Run the L=8 instance up to wcnt=5, then reset for 3 cycles.
      for (int i = 0; i < 8 && cnt8 != 5; i++) tick(1'b1, 2'b01);
      rst = 1'b1;
      #1 check_reset_outputs("rst_mid");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check_reset_outputs($sformatf("rst_hold%0d", i));
      end
      rst  = 1'b0;
      cnt8 = 0;
      cnt5 = 0;
      for (int i = 0; i < 12; i++) tick(1'b1, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
